pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Consumer end of the PLL clock/lock interface. Runs on the PLL output clock (40 MHz pixel domain) and
//  synchronises and filters the PLL LOCK signal. Holds the pixel-domain reset until lock is stable, then
//  releases it. Detects lock loss, re-asserts reset and keeps a sticky flag plus a loss counter.
//  Sits directly after the PLL wrapper and drives reset for the VGA text pipeline.
// PARAMETERS
//  SYNC_STAGES   2    flops in locked synchroniser (>=2)
//  LOCK_FILTER   1024 consecutive synced-high cycles required before lock is accepted
//  DROP_FILTER   4    consecutive synced-low cycles in RUN that count as a lock loss
//  RESET_HOLD    16   cycles rst_out stays high after lock is accepted
//  CNT_W         8    width of loss_count
// PORTS
//  clock         in   1      PLL output clock; all logic on its rising edge
//  reset         in   1      synchronous, active-high; board/user reset
//  locked        in   1      asynchronous PLL LOCK; synchronised internally
//  clear_sticky  in   1      1-cycle pulse; clears lock_lost and loss_count
//  rst_out       out  1      synchronous active-high reset for downstream pixel-domain logic
//  ready         out  1      high only in RUN (== !rst_out)
//  lock_lost     out  1      sticky: set on any lock loss since reset/clear
//  loss_count    out  CNT_W  number of lock losses; saturates at all-ones
// BEHAVIOUR
//  Reset (reset=1): state=WAIT_LOCK, rst_out=1, ready=0, lock_lost=0, loss_count=0, counters=0,
//   synchroniser flops=0. Reset mid-operation aborts any state the next cycle with the same values.
//  lk = last synchroniser stage. Raw locked reaches lk after SYNC_STAGES edges.
//  FSM (rst_out=1 in every state except RUN):
//   WAIT_LOCK: cnt=0. On lk=1 -> FILTER with cnt=1.
//   FILTER: lk=1 -> cnt++. When cnt==LOCK_FILTER-1 and lk=1 -> HOLD, cnt=0. lk=0 at any point -> WAIT_LOCK.
//     No loss is recorded in this state.
//   HOLD: cnt++. When cnt==RESET_HOLD-1 -> RUN. lk=0 -> WAIT_LOCK; no loss is recorded.
//   RUN: rst_out=0, ready=1. dcnt counts consecutive lk=0 cycles and resets to 0 on lk=1.
//     dcnt==DROP_FILTER-1 with lk=0 -> LOST. Shorter drops are ignored.
//   LOST (1 cycle): lock_lost<=1, loss_count<=sat(loss_count+1). Next state WAIT_LOCK.
//  rst_out and ready are registered outputs decoded from next-state; no combinational path from locked.
//  Latency, locked rising (stable) to rst_out falling: SYNC_STAGES + LOCK_FILTER + RESET_HOLD cycles,
//   +/-1 cycle. Compute the exact value and check it in the bench.
//  Latency, locked falling in RUN to rst_out rising: SYNC_STAGES + DROP_FILTER + 1 cycles.
//  clear_sticky: clears lock_lost and loss_count next cycle. If it coincides with LOST, clear wins;
//   the result is lock_lost=0, loss_count=0.
//  loss_count saturates at 2^CNT_W-1 and never wraps. lock_lost still asserts.
//  Counter widths are $clog2 of the max of the filter and hold parameters; no overflow is possible.
//  If clock stops because the PLL is unlocked, state freezes. rst_out is already high by then or
//   asserts once clock resumes with lk=0.
// STRUCTURE
//  Shared package: FSM state enum (WAIT_LOCK, FILTER, HOLD, RUN, LOST) and a clog2-based counter-width
//   helper constant/function, reused by the other reset/clock blocks.
//  One sub-module: sync_ff (SYNC_STAGES-deep single-bit synchroniser, reset to 0). Everything else
//   is inline in this module.
// TESTING  (LOCK_FILTER=8, DROP_FILTER=4, RESET_HOLD=4, SYNC_STAGES=2 unless noted)
//  1 Clean lock: locked=1 from cycle 5 -> rst_out falls and ready rises exactly at the computed cycle
//    (~5+2+8+4). lock_lost=0.
//  2 Lock bounce: locked pulses high for 5 cycles, low for 3, then stays high -> no release during the
//    bounce. The filter restarts, release is measured from the final rise, loss_count=0.
//  3 Glitch in RUN: locked low for 3 cycles -> rst_out stays 0, lock_lost stays 0.
//  4 Real loss in RUN: locked low for 10 cycles, then high -> rst_out=1 within 2+4+1 cycles,
//    lock_lost=1, loss_count=1. After relock, ready returns after the full filter+hold.
//  5 Saturation/clear: CNT_W=2, force 5 losses -> loss_count=3. Pulse clear_sticky coincident with a
//    LOST cycle -> lock_lost=0, loss_count=0.
//  6 Reset mid-HOLD and mid-RUN: assert reset for 1 cycle -> next cycle rst_out=1, ready=0, counters
//    and sticky cleared. Then relock proceeds normally.

Source files
------------

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the PLL lock supervisor and related reset/clock blocks:
// lock FSM state encoding and a helper that sizes internal counters.
package pll_lock_supervisor_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        LOST      = 3'd4
    } lock_state_e;

    // Width that holds every value 0 .. max(a,b,c)-1, never less than 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// Multi-stage single-bit synchroniser for the asynchronous PLL lock input.
// All stages clear to 0 so a reset always presents "not locked".
module pll_lock_supervisor_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input into the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    // Chain registers, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: filters the synchronised PLL lock, holds the pixel-domain
// reset until lock has been stable, releases it, and re-asserts it on lock loss
// while keeping a sticky loss flag and a saturating loss counter.
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 1024,
    parameter int DROP_FILTER = 4,
    parameter int RESET_HOLD  = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             locked,
    input  logic             clear_sticky,
    output logic             rst_out,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count
);

    localparam int CW = cnt_width(LOCK_FILTER, RESET_HOLD, DROP_FILTER);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] DROP_LAST = CW'(DROP_FILTER - 1);

    // Loss counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic lk;

    lock_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    dcnt_q, dcnt_d;
    logic             rst_out_q, rst_out_d;
    logic             ready_q, ready_d;
    logic             lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0] loss_count_q, loss_count_d;

    pll_lock_supervisor_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync_ff (
        .clock (clock),
        .reset (reset),
        .d_in  (locked),
        .q_out (lk)
    );

    // Lock FSM: qualify lock, hold reset, run, and detect sustained drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = '0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lk) begin
                    state_d = FILTER;
                    cnt_d   = CW'(1);
                end
            end
            FILTER: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lk) begin
                    if (dcnt_q == DROP_LAST) begin
                        state_d = LOST;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            LOST: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky loss flag and counter; a clear in the same cycle as LOST wins.
    always_comb begin
        lock_lost_d  = lock_lost_q;
        loss_count_d = loss_count_q;
        if (clear_sticky) begin
            lock_lost_d  = 1'b0;
            loss_count_d = '0;
        end else if (state_q == LOST) begin
            lock_lost_d  = 1'b1;
            loss_count_d = sat_inc(loss_count_q);
        end
    end

    // Outputs decoded from next state so they are registered with no path from locked.
    always_comb begin
        rst_out_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
    end

    // State, counters and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            dcnt_q       <= '0;
            rst_out_q    <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dcnt_q       <= dcnt_d;
            rst_out_q    <= rst_out_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            loss_count_q <= loss_count_d;
        end
    end

    assign rst_out    = rst_out_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor (SYNC=2, LOCK_FILTER=8, DROP=4, HOLD=4, CNT_W=2).
// Stimulus pushes expected rst_out transitions and expected output snapshots;
// a negedge monitor pops them when the DUT changes rst_out or reaches the snapshot cycle.
module tb_pll_lock_supervisor;

    // Hand-computed latencies for this configuration:
    //   release: locked driven high after edge C -> rst_out low after edge C+2+8+4 = C+14
    //   drop:    locked driven low after edge C  -> LOST decided at edge C+2+4 = C+6
    localparam int REL_LAT  = 14;
    localparam int DROP_LAT = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic       locked;
    logic       clear_sticky;
    logic       rst_out;
    logic       ready;
    logic       lock_lost;
    logic [1:0] loss_count;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;
    logic prev_rst;

    typedef struct {
        int   lo;
        int   hi;
        logic val;
    } edge_t;

    typedef struct {
        int         cyc;
        logic       rst;
        logic       ll;
        logic [1:0] cnt;
        int         tag;
    } snap_t;

    edge_t edge_q[$];
    snap_t snap_q[$];

    pll_lock_supervisor #(
        .SYNC_STAGES(2),
        .LOCK_FILTER(8),
        .DROP_FILTER(4),
        .RESET_HOLD (4),
        .CNT_W      (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .locked      (locked),
        .clear_sticky(clear_sticky),
        .rst_out     (rst_out),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .loss_count  (loss_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input string got, input string want);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %s, required %s", nm, cyc, got, want);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic exp_edge(input int lo, input int hi, input logic v);
        edge_t e;
        e.lo = lo; e.hi = hi; e.val = v;
        edge_q.push_back(e);
    endtask

    task automatic exp_snap(input int c, input logic r, input logic ll, input logic [1:0] n, input int tag);
        snap_t s;
        s.cyc = c; s.rst = r; s.ll = ll; s.cnt = n; s.tag = tag;
        snap_q.push_back(s);
    endtask

    // Monitor: compare on every rst_out transition and on every scheduled snapshot.
    edge_t m_e;
    snap_t m_s;
    always @(negedge clock) begin
        if (mon_en) begin
            if (rst_out !== prev_rst) begin
                if (edge_q.size() == 0) begin
                    check(1'b0, "unexpected_rst_edge", $sformatf("rst_out=%b", rst_out), "no transition");
                end else begin
                    m_e = edge_q.pop_front();
                    check(cyc >= m_e.lo && cyc <= m_e.hi && rst_out === m_e.val && ready === ~rst_out,
                          "rst_edge",
                          $sformatf("cyc=%0d rst_out=%b ready=%b", cyc, rst_out, ready),
                          $sformatf("cyc %0d..%0d rst_out=%b ready=%b", m_e.lo, m_e.hi, m_e.val, ~m_e.val));
                end
                prev_rst = rst_out;
            end
            while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
                m_s = snap_q.pop_front();
                check(m_s.cyc == cyc && rst_out === m_s.rst && ready === ~m_s.rst &&
                      lock_lost === m_s.ll && loss_count === m_s.cnt,
                      $sformatf("snap%0d", m_s.tag),
                      $sformatf("cyc=%0d rst=%b rdy=%b ll=%b cnt=%0d", cyc, rst_out, ready, lock_lost, loss_count),
                      $sformatf("cyc=%0d rst=%b rdy=%b ll=%b cnt=%0d", m_s.cyc, m_s.rst, ~m_s.rst, m_s.ll, m_s.cnt));
            end
        end
    end

    // One loss: drop locked 10 cycles, optionally clear in the LOST cycle, relock.
    task automatic do_loss(input int exp_cnt, input bit clr, input int tag);
        int c;
        c = cyc;
        locked = 1'b0;
        exp_edge(c + DROP_LAT, c + DROP_LAT + 1, 1'b1);
        if (clr) begin
            wait_to(c + DROP_LAT);
            clear_sticky = 1'b1;
            wait_to(c + DROP_LAT + 1);
            clear_sticky = 1'b0;
        end
        wait_to(c + 8);
        exp_snap(c + 9, 1'b1, clr ? 1'b0 : 1'b1, clr ? 2'd0 : 2'(exp_cnt), tag);
        wait_to(c + 10);
        locked = 1'b1;
        exp_edge(c + 10 + REL_LAT, c + 10 + REL_LAT, 1'b0);
        exp_snap(c + 27, 1'b0, clr ? 1'b0 : 1'b1, clr ? 2'd0 : 2'(exp_cnt), tag + 1);
        wait_to(c + 28);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1;
        locked = 1'b0;
        clear_sticky = 1'b0;
        wait_to(3);
        reset = 1'b0;
        prev_rst = 1'b1;
        mon_en = 1'b1;
        exp_snap(3, 1'b1, 1'b0, 2'd0, 0);

        // Clean lock from cycle 5.
        wait_to(5);
        locked = 1'b1;
        exp_edge(5 + REL_LAT, 5 + REL_LAT, 1'b0);
        exp_snap(18, 1'b1, 1'b0, 2'd0, 1);
        exp_snap(25, 1'b0, 1'b0, 2'd0, 2);
        wait_to(26);

        // Three-cycle glitch in RUN is ignored.
        c = cyc;
        locked = 1'b0;
        wait_to(c + 3);
        locked = 1'b1;
        exp_snap(c + 10, 1'b0, 1'b0, 2'd0, 3);
        wait_to(c + 12);

        // Real loss, then four more to reach saturation at 3.
        do_loss(1, 1'b0, 10);
        for (int k = 2; k <= 5; k++) begin
            do_loss((k > 3) ? 3 : k, 1'b0, 10 + 2 * k);
        end

        // Clear coincident with LOST, then one more loss from zero.
        do_loss(0, 1'b1, 30);
        do_loss(1, 1'b0, 32);

        // Reset mid-RUN, then reset mid-HOLD of the following relock.
        c = cyc;
        reset = 1'b1;
        exp_edge(c + 1, c + 1, 1'b1);
        wait_to(c + 1);
        reset = 1'b0;
        exp_snap(c + 2, 1'b1, 1'b0, 2'd0, 40);
        wait_to(c + 12);
        reset = 1'b1;
        wait_to(c + 13);
        reset = 1'b0;
        exp_snap(c + 14, 1'b1, 1'b0, 2'd0, 41);
        exp_edge(c + 13 + REL_LAT, c + 13 + REL_LAT, 1'b0);
        exp_snap(c + 30, 1'b0, 1'b0, 2'd0, 42);
        wait_to(c + 31);

        // Lock bounce from WAIT_LOCK: 5 high, 3 low, then stable high.
        locked = 1'b0;
        c = cyc;
        reset = 1'b1;
        exp_edge(c + 1, c + 1, 1'b1);
        wait_to(c + 2);
        reset = 1'b0;
        c = cyc + 2;
        wait_to(c);
        locked = 1'b1;
        wait_to(c + 5);
        locked = 1'b0;
        wait_to(c + 8);
        locked = 1'b1;
        exp_edge(c + 8 + REL_LAT, c + 8 + REL_LAT, 1'b0);
        exp_snap(c + 21, 1'b1, 1'b0, 2'd0, 50);
        exp_snap(c + 25, 1'b0, 1'b0, 2'd0, 51);
        wait_to(c + 35);

        check(edge_q.size() == 0, "pending_edges", $sformatf("%0d left", edge_q.size()), "0 left");
        check(snap_q.size() == 0, "pending_snaps", $sformatf("%0d left", snap_q.size()), "0 left");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
